conditioned_operand_stage: RTL



---
 rtl/ppu_pkg.sv | 42 ++++
 rtl/skid_reg.sv | 83 ++++++++
 rtl/conditioned_operand_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: op codes, posit special words, stage bundle type
// and the state encoding of the 2-entry skid register.
package ppu_pkg;

  localparam int OP_SIZE   = 3;
  localparam int N_DEF     = 16;
  localparam int TAG_W_DEF = 8;

  typedef enum logic [OP_SIZE-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3
  } op_e;

  // Posit zero is all zeros; NaR (NaN) is the sign bit alone.
  function automatic logic [63:0] posit_zero(input int unsigned n);
    return 64'(0) & ((64'h1 << n) - 64'h1);
  endfunction

  function automatic logic [63:0] posit_nan(input int unsigned n);
    return 64'h1 << (n - 1);
  endfunction

  // Bundle carried from operand conditioning to the arithmetic core
  // (default widths; the stage re-declares it for its own N and TAG_W).
  typedef struct packed {
    logic [N_DEF-1:0]     p1;
    logic [N_DEF-1:0]     p2;
    logic [OP_SIZE-1:0]   op;
    logic                 special;
    logic [N_DEF-1:0]     pout_special;
    logic [TAG_W_DEF-1:0] tag;
  } cond_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_reg.sv
// Generic 2-entry valid/ready register. in_ready is registered, so the
// upstream combinational path stops at this stage.
//
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main register valid, presented on out_data
//   FULL  | main and skid valid; skid is the younger entry
module skid_reg
  import ppu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire, out_fire;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = (state_q != EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  // Next state and data movement; registers hold unless explicitly loaded.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // State, ready and storage registers; reset clears everything, ready included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/conditioned_operand_stage.sv
// Pipeline stage between operand conditioning and the PPU core. Buffers the
// conditioned bundle in a 2-entry skid register and stamps each accepted
// bundle with a wrapping sequence tag.
// Optional: define SPECIAL_COUNT_EN to add special_cnt, a saturating count
// of delivered special bundles.
module conditioned_operand_stage
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_p1,
  input  logic [N-1:0]       in_p2,
  input  logic [OP_SIZE-1:0] in_op,
  input  logic               in_special,
  input  logic [N-1:0]       in_pout_special,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_p1,
  output logic [N-1:0]       out_p2,
  output logic [OP_SIZE-1:0] out_op,
  output logic               out_special,
  output logic [N-1:0]       out_pout_special,
  output logic [TAG_W-1:0]   out_tag
`ifdef SPECIAL_COUNT_EN
  ,
  output logic [15:0]        special_cnt
`endif
);

  // Same layout as ppu_pkg::cond_bundle_t, sized by this instance.
  typedef struct packed {
    logic [N-1:0]       p1;
    logic [N-1:0]       p2;
    logic [OP_SIZE-1:0] op;
    logic               special;
    logic [N-1:0]       pout_special;
    logic [TAG_W-1:0]   tag;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  bundle_t          in_bundle, out_bundle;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             in_fire;

  assign in_fire = in_valid & in_ready;

  // Assemble the incoming bundle; the special result is dropped when unused.
  always_comb begin
    in_bundle              = '0;
    in_bundle.p1           = in_p1;
    in_bundle.p2           = in_p2;
    in_bundle.op           = in_op;
    in_bundle.special      = in_special;
    in_bundle.pout_special = in_special ? in_pout_special : '0;
    in_bundle.tag          = tag_q;
  end

  skid_reg #(
    .W(BW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_bundle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_bundle)
  );

  assign out_p1           = out_bundle.p1;
  assign out_p2           = out_bundle.p2;
  assign out_op           = out_bundle.op;
  assign out_special      = out_bundle.special;
  assign out_pout_special = out_bundle.special ? out_bundle.pout_special : '0;
  assign out_tag          = out_bundle.tag;

  // Tag advances once per accepted input and wraps naturally.
  always_comb begin
    tag_d = tag_q;
    if (in_fire) tag_d = tag_q + 1'b1;
  end

  // Tag counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

`ifdef SPECIAL_COUNT_EN
  logic        out_fire;
  logic [15:0] special_cnt_q, special_cnt_d;

  assign out_fire    = out_valid & out_ready;
  assign special_cnt = special_cnt_q;

  // Count delivered special bundles, holding at the maximum.
  always_comb begin
    special_cnt_d = special_cnt_q;
    if (out_fire && out_bundle.special && (special_cnt_q != 16'hFFFF))
      special_cnt_d = special_cnt_q + 16'd1;
  end

  // Special counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) special_cnt_q <= 16'd0;
    else     special_cnt_q <= special_cnt_d;
  end
`endif

endmodule
